// File: rtl/btn_input_ctrl.sv
// ---------------------------------------------------------------------------
// btn_input_ctrl
//
// Push-button front end for the LED pattern stage. Two raw board buttons are
// each synchronized, debounced by a tick-sampled FSM and turned into a
// one-cycle press pulse. The run/pause level `en` and the shift-direction
// level `dir` toggle on those pulses and feed the pattern FSM directly.
//
// Optional feature macro: BTN_LONGPRESS_EN
//   Defined   : holding btn_en in the accepted-pressed state for LONG_TICKS
//               ticks fires a one-cycle soft_rst and forces en=1, dir=0.
//   Undefined : no hold counter, soft_rst tied to 0, LONG_TICKS ignored.
//
// Parameters
//   TICK_DIV   : sample-tick period in clk cycles (>= 2)
//   DB_TICKS   : consecutive equal samples to accept a level change (>= 1)
//   LONG_TICKS : long-press hold length in ticks (macro builds only)
//
// Ports
//   clk        in   system clock, the only clock
//   rst        in   asynchronous active-high reset
//   btn_en     in   raw run/pause button, async to clk, 1 = pressed
//   btn_dir    in   raw direction button, async to clk, 1 = pressed
//   en         out  run level, reset 1
//   dir        out  direction level, reset 0
//   en_pulse   out  one-cycle pulse per accepted btn_en press
//   dir_pulse  out  one-cycle pulse per accepted btn_dir press
//   soft_rst   out  one-cycle long-press pulse (0 when compiled out)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// btn_input_ctrl_lane
//
// One button: 2-FF synchronizer followed by the debounce FSM.
//
// Ports
//   clk, rst  in   clock / async active-high reset
//   tick      in   shared sample strobe from the prescaler
//   btn       in   raw asynchronous button pin
//   s         out  synchronized button bit
//   press     out  combinational: this clk edge enters PRESSED
//   pulse     out  registered one-cycle press pulse
//   pressed   out  FSM currently in PRESSED
// ---------------------------------------------------------------------------
module btn_input_ctrl_lane #(
  parameter int DB_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic s,
  output logic press,
  output logic pulse,
  output logic pressed
);

  localparam int            CW      = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_TICKS);
  // With a single required sample the check states are skipped entirely.
  localparam bit            DB_ONE  = (DB_TICKS == 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_t;

  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    sync_pipe;

  // Two-flop synchronizer; bit 1 is the only copy later logic may look at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], btn};
  end

  assign s       = sync_pipe[1];
  assign cnt_inc = cnt + 1'b1;
  assign pressed = (state == PRESSED);

  // Exposed combinationally so the level registers in the top can toggle on
  // the very edge that registers the pulse.
  assign press = tick && s &&
                 (((state == RELEASED) && DB_ONE) ||
                  ((state == PRESS_CHK) && (cnt_inc == CNT_MAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= press;
      if (tick) begin
        case (state)
          RELEASED: begin
            if (s) begin
              if (DB_ONE) begin
                state <= PRESSED;
              end else begin
                cnt   <= CW'(1);
                state <= PRESS_CHK;
              end
            end
          end
          PRESS_CHK: begin
            if (s) begin
              if (cnt_inc == CNT_MAX) begin
                cnt   <= '0;
                state <= PRESSED;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              // glitch: abandon the check silently
              cnt   <= '0;
              state <= RELEASED;
            end
          end
          PRESSED: begin
            if (!s) begin
              if (DB_ONE) begin
                state <= RELEASED;
              end else begin
                cnt   <= CW'(1);
                state <= RELEASE_CHK;
              end
            end
          end
          RELEASE_CHK: begin
            if (!s) begin
              if (cnt_inc == CNT_MAX) begin
                cnt   <= '0;
                state <= RELEASED;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= '0;
              state <= PRESSED;
            end
          end
          default: begin
            cnt   <= '0;
            state <= RELEASED;
          end
        endcase
      end
    end
  end

endmodule

module btn_input_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int DB_TICKS   = 8,
  parameter int LONG_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_en,
  input  logic btn_dir,
  output logic en,
  output logic dir,
  output logic en_pulse,
  output logic dir_pulse,
  output logic soft_rst
);

  // lane 0 = btn_en, lane 1 = btn_dir
  localparam int            NUM_LANES = 2;
  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);

  logic [NUM_LANES-1:0] btn_raw;
  logic [NUM_LANES-1:0] s;
  logic [NUM_LANES-1:0] press;
  logic [NUM_LANES-1:0] pulse;
  logic [NUM_LANES-1:0] pressed;
  logic [PW-1:0]        pre_cnt;
  logic                 tick;

  assign btn_raw = {btn_dir, btn_en};

  // Shared prescaler: the only thing the two lanes have in common.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == PRE_MAX);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    btn_input_ctrl_lane #(
      .DB_TICKS(DB_TICKS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .btn    (btn_raw[i]),
      .s      (s[i]),
      .press  (press[i]),
      .pulse  (pulse[i]),
      .pressed(pressed[i])
    );
  end

  assign en_pulse  = pulse[0];
  assign dir_pulse = pulse[1];

`ifdef BTN_LONGPRESS_EN
  localparam int            HW       = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [HW-1:0] hold_cnt;
  logic          long_evt;
  logic          unused_lane;

  assign unused_lane = ^{pressed[1], s[1]};

  // Counts ticks spent in PRESSED; a tick that samples a release leaves
  // PRESSED and so clears rather than counts. Saturates so the event fires
  // once per press.
  assign long_evt = pressed[0] && tick && s[0] && (hold_cnt == HOLD_MAX - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              hold_cnt <= '0;
    else if (!pressed[0] || (tick && !s[0])) hold_cnt <= '0;
    else if (tick && (hold_cnt != HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
  end

  // Long-press wins over any toggle landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b1;
      dir      <= 1'b0;
      soft_rst <= 1'b0;
    end else begin
      soft_rst <= long_evt;
      if (long_evt) begin
        en  <= 1'b1;
        dir <= 1'b0;
      end else begin
        en  <= en ^ press[0];
        dir <= dir ^ press[1];
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{LONG_TICKS, pressed, s};
  assign soft_rst   = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en  <= 1'b1;
      dir <= 1'b0;
    end else begin
      en  <= en ^ press[0];
      dir <= dir ^ press[1];
    end
  end
`endif

endmodule
